// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multi-cycle RV32I main control unit, its
// datapath and the ALU control decoder.
//   - state_t     : 4-bit encoding of the 13 control states
//   - OP_*        : supported major opcodes (instr[6:0])
//   - ALUOP_*     : aluop encodings seen by the ALU control decoder
//   - SRC_A_*     : ALU A operand mux selects
//   - SRC_B_*     : ALU B operand mux selects
//   - RES_*       : writeback (result) mux selects
//   - decode_next : DECODE-state dispatch on the opcode
// ---------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_I    = 4'd4,
        S_ALU_WB    = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Maps the major opcode to the first state after DECODE; any opcode
    // the core does not implement lands in the trapping ILLEGAL state.
    function automatic state_t decode_next(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_R:                nxt = S_EXEC_R;
            OP_IMM:              nxt = S_EXEC_I;
            OP_LOAD, OP_STORE:   nxt = S_MEM_ADDR;
            OP_BRANCH:           nxt = S_BRANCH;
            OP_JAL:              nxt = S_JAL;
            default:             nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
// Multi-cycle main control unit for the RV32I core. Sequences
// fetch/decode/execute/memory/writeback and drives every datapath enable
// and mux select, plus a ready-based handshake with the unified memory.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset, forces IDLE
//   opcode[6:0]   in   instr[6:0] from the instruction register
//   zero          in   ALU zero flag, meaningful in BRANCH
//   mem_ready     in   memory completes the current request this cycle
//   mem_req       out  memory request, held until mem_ready
//   mem_we        out  write qualifier for mem_req
//   iord          out  memory address select (0 = PC, 1 = ALUOut)
//   ir_write      out  load IR and OldPC
//   pc_write      out  load PC
//   pc_source     out  PC input select (0 = ALU result, 1 = ALUOut)
//   reg_write     out  register file write enable
//   result_src    out  writeback select (00 ALUOut, 01 mem, 10 ALU)
//   alu_src_a     out  ALU A select (00 PC, 01 rs1, 10 OldPC)
//   alu_src_b     out  ALU B select (00 rs2, 01 four, 10 imm)
//   aluop         out  to the ALU control decoder
//   illegal_instr out  sticky unsupported-opcode flag
// ---------------------------------------------------------------------------
module main_control_fsm
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_source,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       illegal_instr
);

    state_t state;
    state_t next_state;

    // State register; reset drops straight to IDLE so every output
    // (all decoded from state) goes low without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Outputs are Moore except the
    // mem_ready-gated IR/PC loads in FETCH and the zero-gated PC load in
    // BRANCH, so a stalled fetch never commits anything.
    always_comb begin
        next_state    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_source     = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        aluop         = ALUOP_ADD;
        illegal_instr = 1'b0;

        unique case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                aluop     = ALUOP_ADD;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute OldPC + imm into ALUOut for branch/jump targets.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_IMM;
                aluop      = ALUOP_ADD;
                next_state = decode_next(opcode);
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                // Only LOAD and STORE reach here, and the IR is frozen,
                // so checking for STORE alone is enough.
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                aluop      = ALUOP_ADD;
                next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                aluop      = ALUOP_SUB;
                pc_source  = 1'b1;
                pc_write   = zero;
                next_state = S_FETCH;
            end
            S_JAL: begin
                // Link value is OldPC + 4 from the ALU; target sits in ALUOut.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                aluop      = ALUOP_ADD;
                pc_source  = 1'b1;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_ALU;
                next_state = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_instr = 1'b1;
                next_state    = S_ILLEGAL;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
// Directed bench for main_control_fsm. All outputs are packed into one
// 16-bit word; each state has a hand-written expected signature:
//   [15] mem_req [14] mem_we [13] iord [12] ir_write [11] pc_write
//   [10] pc_source [9] reg_write [8:7] result_src [6:5] alu_src_a
//   [4:3] alu_src_b [2:1] aluop [0] illegal_instr
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

    localparam logic [15:0] E_IDLE    = 16'h0000;
    localparam logic [15:0] E_FETCH   = 16'h9808;
    localparam logic [15:0] E_FWAIT   = 16'h8008;
    localparam logic [15:0] E_DECODE  = 16'h0050;
    localparam logic [15:0] E_EXEC_R  = 16'h0024;
    localparam logic [15:0] E_EXEC_I  = 16'h0034;
    localparam logic [15:0] E_ALU_WB  = 16'h0200;
    localparam logic [15:0] E_MADDR   = 16'h0030;
    localparam logic [15:0] E_MREAD   = 16'hA000;
    localparam logic [15:0] E_MWB     = 16'h0280;
    localparam logic [15:0] E_MWRITE  = 16'hE000;
    localparam logic [15:0] E_BR_T    = 16'h0C22;
    localparam logic [15:0] E_BR_N    = 16'h0422;
    localparam logic [15:0] E_JAL     = 16'h0F48;
    localparam logic [15:0] E_ILLEGAL = 16'h0001;

    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_IMM  = 7'b0010011;
    localparam logic [6:0] T_LD   = 7'b0000011;
    localparam logic [6:0] T_ST   = 7'b0100011;
    localparam logic [6:0] T_BEQ  = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_BAD  = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_source;
    logic       reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, aluop;
    logic [15:0] obs;

    int checks = 0;
    int failures = 0;

    main_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .aluop(aluop), .illegal_instr(illegal_instr)
    );

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_source,
                  reg_write, result_src, alu_src_a, alu_src_b, aluop,
                  illegal_instr};

    always #5 clk = ~clk;

    // Advance one clock, then set this cycle's inputs mid-cycle and let
    // combinational outputs settle before the caller samples them.
    task automatic cycle(input logic mr, input logic z, input logic [6:0] op);
        @(posedge clk);
        #2;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        #1;
    endtask

    // Leaves the DUT in IDLE, mid-cycle, one edge before the first FETCH.
    task automatic reset_dut();
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        #1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = T_R;
        @(posedge clk);
        #3;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("[TB] FAIL reset_held outs: got %h expected %h", obs, E_IDLE);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("[TB] FAIL reset_first_cycle outs: got %h expected %h", obs, E_IDLE);
        end
        cycle(1'b1, 1'b0, T_R);
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("[TB] FAIL reset_second_cycle outs: got %h expected %h", obs, E_FETCH);
        end
    endtask

    task automatic test_r_type();
        logic [15:0] exp_o [6] = '{E_FETCH, E_DECODE, E_EXEC_R, E_ALU_WB, E_FETCH, E_DECODE};
        int rw_pulses = 0;
        reset_dut();
        opcode = T_R;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, T_R);
            if (i < 5 && reg_write) rw_pulses++;
            checks++;
            if (obs !== exp_o[i]) begin
                failures++;
                $display("[TB] FAIL r_type step %0d outs: got %h expected %h", i, obs, exp_o[i]);
            end
            if (i == 2) begin
                checks++;
                if (aluop !== 2'b10) begin
                    failures++;
                    $display("[TB] FAIL r_type_aluop: got %b expected 10", aluop);
                end
            end
        end
        checks++;
        if (rw_pulses !== 1) begin
            failures++;
            $display("[TB] FAIL r_type_reg_write_pulses: got %0d expected 1", rw_pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_o [9] = '{E_FWAIT, E_FETCH, E_DECODE, E_EXEC_R, E_ALU_WB,
                                   E_FETCH, E_DECODE, E_EXEC_I, E_ALU_WB};
        logic        mr [9]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [6:0]  op [9]    = '{T_R, T_R, T_R, T_R, T_IMM, T_IMM, T_IMM, T_IMM, T_IMM};
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            cycle(mr[i], 1'b0, op[i]);
            checks++;
            if (obs !== exp_o[i]) begin
                failures++;
                $display("[TB] FAIL back_to_back step %0d outs: got %h expected %h", i, obs, exp_o[i]);
            end
        end
    endtask

    task automatic test_load_wait();
        logic [15:0] exp_o [8] = '{E_FETCH, E_DECODE, E_MADDR, E_MREAD, E_MREAD,
                                   E_MREAD, E_MWB, E_FETCH};
        logic        mr [8]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat = 0;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            cycle(mr[i], 1'b0, T_LD);
            if (lat == 0 && reg_write) lat = i + 1;
            checks++;
            if (obs !== exp_o[i]) begin
                failures++;
                $display("[TB] FAIL load step %0d outs: got %h expected %h", i, obs, exp_o[i]);
            end
        end
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("[TB] FAIL load_latency: got %0d expected 7", lat);
        end
    endtask

    task automatic test_store();
        logic [15:0] exp_o [6] = '{E_FETCH, E_DECODE, E_MADDR, E_MWRITE, E_MWRITE, E_FETCH};
        logic        mr [6]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            cycle(mr[i], 1'b0, T_ST);
            checks++;
            if (obs !== exp_o[i]) begin
                failures++;
                $display("[TB] FAIL store step %0d outs: got %h expected %h", i, obs, exp_o[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [15:0] exp_o [7] = '{E_FETCH, E_DECODE, E_BR_T, E_FETCH, E_DECODE, E_BR_N, E_FETCH};
        logic        z [7]     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        reset_dut();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, z[i], T_BEQ);
            checks++;
            if (obs !== exp_o[i]) begin
                failures++;
                $display("[TB] FAIL branch step %0d outs: got %h expected %h", i, obs, exp_o[i]);
            end
        end
    endtask

    task automatic test_jal();
        logic [15:0] exp_o [4] = '{E_FETCH, E_DECODE, E_JAL, E_FETCH};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, T_JAL);
            checks++;
            if (obs !== exp_o[i]) begin
                failures++;
                $display("[TB] FAIL jal step %0d outs: got %h expected %h", i, obs, exp_o[i]);
            end
        end
    endtask

    task automatic test_illegal();
        reset_dut();
        cycle(1'b1, 1'b0, T_BAD);
        cycle(1'b1, 1'b0, T_BAD);
        for (int i = 0; i < 12; i++) begin
            cycle(i[0], i[1], (i < 6) ? T_BAD : T_R);
            checks++;
            if (obs !== E_ILLEGAL) begin
                failures++;
                $display("[TB] FAIL illegal_hold step %0d outs: got %h expected %h", i, obs, E_ILLEGAL);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("[TB] FAIL illegal_reset outs: got %h expected %h", obs, E_IDLE);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("[TB] FAIL illegal_idle outs: got %h expected %h", obs, E_IDLE);
        end
        cycle(1'b1, 1'b0, T_R);
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("[TB] FAIL illegal_refetch outs: got %h expected %h", obs, E_FETCH);
        end
    endtask

    task automatic test_reset_mid_fetch();
        reset_dut();
        cycle(1'b0, 1'b0, T_R);
        cycle(1'b0, 1'b0, T_R);
        checks++;
        if (obs !== E_FWAIT) begin
            failures++;
            $display("[TB] FAIL midfetch_wait outs: got %h expected %h", obs, E_FWAIT);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("[TB] FAIL midfetch_async_drop outs: got %h expected %h", obs, E_IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, T_R);
            checks++;
            if (obs !== E_IDLE) begin
                failures++;
                $display("[TB] FAIL midfetch_held step %0d outs: got %h expected %h", i, obs, E_IDLE);
            end
        end
        reset = 1'b0;
        #1;
        cycle(1'b1, 1'b0, T_R);
        checks++;
        if (obs !== E_FETCH) begin
            failures++;
            $display("[TB] FAIL midfetch_recover outs: got %h expected %h", obs, E_FETCH);
        end
    endtask

    // Runs every scenario in order, then reports the totals.
    initial begin
        test_reset();
        test_r_type();
        test_back_to_back();
        test_load_wait();
        test_store();
        test_branch();
        test_jal();
        test_illegal();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
